image_proc_ctrl: RTL and testbench

Frame-level controller that sits between the camera capture stage and `image_processing_module`. It qualifies the raw pixel stream with frame/line validity, generates the `iX_Cont`/`iY_Cont` coordinates the processing module consumes, and sequences start/stop of capture. It also owns the processing-mode register, applying host mode requests only at frame boundaries through a request/acknowledge handshake so a frame is never processed in two modes.

---
 rtl/image_proc_ctrl.sv | 149 ++++++++++++++
 tb/tb_image_proc_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/image_proc_ctrl.sv
// rtl/image_proc_ctrl.sv - frame qualification, coordinate generation and frame-aligned mode control
module image_proc_ctrl #(
    parameter int IMG_WIDTH  = 1280,
    parameter int IMG_HEIGHT = 960
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic        iFVAL,
    input  logic        iDVAL,
    input  logic [11:0] iDATA,
    input  logic        iCFG_REQ,
    input  logic [1:0]  iCFG_MODE,
    input  logic        iERR_CLR,
    output logic [11:0] oDATA,
    output logic        oDVAL,
    output logic [10:0] oX_Cont,
    output logic [10:0] oY_Cont,
    output logic        oSOF,
    output logic        oEOF,
    output logic [1:0]  oMODE,
    output logic        oCFG_BUSY,
    output logic        oCFG_ACK,
    output logic [15:0] oFRAME_CNT,
    output logic        oERR
);

    typedef enum logic [1:0] {IDLE, ARMED, ACTIVE, DONE} state_t;

    localparam logic [10:0] X_LAST = 11'(IMG_WIDTH - 1);
    localparam logic [10:0] Y_LAST = 11'(IMG_HEIGHT - 1);

    state_t      state, state_nxt;
    logic        fval_q;
    logic        fval_rise, fval_fall;
    logic [10:0] x, y, x_nxt, y_nxt, cur_x, cur_y;
    logic        full, full_nxt, cur_full;
    logic        start_frame, take, fwd, overrun, last, size_err, apply;
    logic [1:0]  pending;

    assign fval_rise = iFVAL & ~fval_q;
    assign fval_fall = ~iFVAL & fval_q;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state  <= IDLE;
            fval_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            fval_q <= iFVAL;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        case (state)
            IDLE:   if (iSTART) state_nxt = ARMED;
            ARMED: begin
                if (!iSTART) begin
                    state_nxt = IDLE;
                end else if (fval_rise) begin
                    state_nxt   = ACTIVE;
                    start_frame = 1'b1;
                end
            end
            ACTIVE: if (fval_fall) state_nxt = DONE;
            DONE:   state_nxt = iSTART ? ARMED : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The rising-edge cycle itself may carry the first pixel, so counters restart combinationally.
    always_comb begin
        cur_x    = start_frame ? 11'd0 : x;
        cur_y    = start_frame ? 11'd0 : y;
        cur_full = start_frame ? 1'b0 : full;
        take     = iFVAL & iDVAL & ((state == ACTIVE) | start_frame);
        fwd      = take & ~cur_full;
        overrun  = take & cur_full;
        last     = (cur_x == X_LAST) && (cur_y == Y_LAST);
        size_err = (state == ACTIVE) & fval_fall & ~full;
        apply    = oCFG_BUSY & (state != ACTIVE);
        x_nxt    = cur_x;
        y_nxt    = cur_y;
        full_nxt = cur_full;
        if (fwd) begin
            if (last) begin
                full_nxt = 1'b1;
            end else if (cur_x == X_LAST) begin
                x_nxt = 11'd0;
                y_nxt = cur_y + 11'd1;
            end else begin
                x_nxt = cur_x + 11'd1;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            x       <= 11'd0;
            y       <= 11'd0;
            full    <= 1'b0;
            oDATA   <= 12'd0;
            oDVAL   <= 1'b0;
            oX_Cont <= 11'd0;
            oY_Cont <= 11'd0;
            oSOF    <= 1'b0;
            oEOF    <= 1'b0;
        end else begin
            x     <= x_nxt;
            y     <= y_nxt;
            full  <= full_nxt;
            oDVAL <= fwd;
            oSOF  <= fwd && (cur_x == 11'd0) && (cur_y == 11'd0);
            oEOF  <= fwd && last;
            if (fwd) begin
                oDATA   <= iDATA;
                oX_Cont <= cur_x;
                oY_Cont <= cur_y;
            end
        end
    end

    // Pending mode is applied only outside ACTIVE, so a frame never sees two modes.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            pending    <= 2'd0;
            oCFG_BUSY  <= 1'b0;
            oCFG_ACK   <= 1'b0;
            oMODE      <= 2'd0;
            oFRAME_CNT <= 16'd0;
            oERR       <= 1'b0;
        end else begin
            oCFG_ACK <= apply;
            if (apply) oMODE <= pending;
            if (iCFG_REQ) begin
                pending   <= iCFG_MODE;
                oCFG_BUSY <= 1'b1;
            end else if (apply) begin
                oCFG_BUSY <= 1'b0;
            end
            if (state == DONE) oFRAME_CNT <= oFRAME_CNT + 16'd1;
            if (overrun || size_err) oERR <= 1'b1;
            else if (iERR_CLR)       oERR <= 1'b0;
        end
    end

endmodule

// File: tb/tb_image_proc_ctrl.sv
// tb/tb_image_proc_ctrl.sv - scoreboard bench for image_proc_ctrl with a 6x4 frame
module tb_image_proc_ctrl;

    localparam int W = 6;
    localparam int H = 4;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iSTART, iFVAL, iDVAL, iCFG_REQ, iERR_CLR;
    logic [11:0] iDATA;
    logic [1:0]  iCFG_MODE;
    logic [11:0] oDATA;
    logic        oDVAL, oSOF, oEOF, oCFG_BUSY, oCFG_ACK, oERR;
    logic [10:0] oX_Cont, oY_Cont;
    logic [1:0]  oMODE;
    logic [15:0] oFRAME_CNT;

    image_proc_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iFVAL(iFVAL), .iDVAL(iDVAL),
        .iDATA(iDATA), .iCFG_REQ(iCFG_REQ), .iCFG_MODE(iCFG_MODE), .iERR_CLR(iERR_CLR),
        .oDATA(oDATA), .oDVAL(oDVAL), .oX_Cont(oX_Cont), .oY_Cont(oY_Cont),
        .oSOF(oSOF), .oEOF(oEOF), .oMODE(oMODE), .oCFG_BUSY(oCFG_BUSY),
        .oCFG_ACK(oCFG_ACK), .oFRAME_CNT(oFRAME_CNT), .oERR(oERR)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [11:0] d;
        logic [10:0] x;
        logic [10:0] y;
        logic        sof;
        logic        eof;
        logic [1:0]  mode;
    } pix_t;

    pix_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    int         ack_cnt = 0;
    logic [1:0] exp_mode = 2'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge iCLK) begin
        if (iRST === 1'b1) begin
            if (oCFG_ACK === 1'b1) ack_cnt++;
            if (oDVAL === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_dval", 32'd1, 32'd0);
                end else begin
                    pix_t e;
                    e = sb.pop_front();
                    check("pix_data", 32'(oDATA), 32'(e.d));
                    check("pix_x", 32'(oX_Cont), 32'(e.x));
                    check("pix_y", 32'(oY_Cont), 32'(e.y));
                    check("pix_sof", 32'(oSOF), 32'(e.sof));
                    check("pix_eof", 32'(oEOF), 32'(e.eof));
                    check("pix_mode", 32'(oMODE), 32'(e.mode));
                end
            end
        end
    end

    task automatic tick();
        @(negedge iCLK);
    endtask

    task automatic send_frame(input int n, input int nexp, input int req1, input int m1,
                              input int req2, input int m2, input int stop_at);
        iFVAL = 1'b1;
        iDVAL = 1'b0;
        tick();
        for (int i = 0; i < n; i++) begin
            pix_t e;
            iDVAL     = 1'b1;
            iDATA     = 12'(100 + i);
            iCFG_REQ  = (i == req1) || (i == req2);
            iCFG_MODE = (i == req2) ? 2'(m2) : 2'(m1);
            if (i == stop_at) iSTART = 1'b0;
            if (i < nexp) begin
                e.d = 12'(100 + i);
                e.x = 11'(i % W);
                e.y = 11'(i / W);
                e.sof = (i == 0);
                e.eof = (i == W * H - 1);
                e.mode = exp_mode;
                sb.push_back(e);
            end
            tick();
        end
        iDVAL    = 1'b0;
        iCFG_REQ = 1'b0;
        tick();
        iFVAL = 1'b0;
        repeat (4) tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int acks;
        iRST = 1'b0; iSTART = 1'b0; iFVAL = 1'b0; iDVAL = 1'b0; iDATA = 12'd0;
        iCFG_REQ = 1'b0; iCFG_MODE = 2'd0; iERR_CLR = 1'b0;
        repeat (3) tick();
        check("rst_dval", 32'(oDVAL), 32'd0);
        check("rst_mode", 32'(oMODE), 32'd0);
        check("rst_cnt", 32'(oFRAME_CNT), 32'd0);
        check("rst_err", 32'(oERR), 32'd0);
        check("rst_busy", 32'(oCFG_BUSY), 32'd0);
        iRST = 1'b1;
        tick();

        // Full frame
        iSTART = 1'b1;
        repeat (2) tick();
        send_frame(24, 24, -1, 0, -1, 0, -1);
        check("f1_cnt", 32'(oFRAME_CNT), 32'd1);
        check("f1_err", 32'(oERR), 32'd0);

        // Two requests during a frame: mode holds, one ack, last value wins
        acks = ack_cnt;
        send_frame(24, 24, 5, 2, 15, 3, -1);
        check("cfg_ack_once", 32'(ack_cnt - acks), 32'd1);
        check("cfg_mode3", 32'(oMODE), 32'd3);
        check("cfg_busy_clr", 32'(oCFG_BUSY), 32'd0);
        check("f2_cnt", 32'(oFRAME_CNT), 32'd2);

        // Request while ARMED applies right away
        acks = ack_cnt;
        iCFG_REQ = 1'b1; iCFG_MODE = 2'd1;
        tick();
        iCFG_REQ = 1'b0;
        check("armed_busy", 32'(oCFG_BUSY), 32'd1);
        repeat (2) tick();
        check("armed_mode1", 32'(oMODE), 32'd1);
        check("armed_ack", 32'(ack_cnt - acks), 32'd1);
        exp_mode = 2'd1;

        // Short frame
        send_frame(20, 20, -1, 0, -1, 0, -1);
        check("short_err", 32'(oERR), 32'd1);
        check("short_cnt", 32'(oFRAME_CNT), 32'd3);
        iERR_CLR = 1'b1;
        tick();
        iERR_CLR = 1'b0;
        tick();
        check("err_clr", 32'(oERR), 32'd0);

        // Long frame: only W*H forwarded
        send_frame(30, 24, -1, 0, -1, 0, -1);
        check("long_err", 32'(oERR), 32'd1);
        check("long_cnt", 32'(oFRAME_CNT), 32'd4);
        iERR_CLR = 1'b1;
        tick();
        iERR_CLR = 1'b0;
        tick();

        // Stop mid-frame: frame completes, following frame ignored
        send_frame(24, 24, -1, 0, -1, 0, 10);
        check("stop_cnt", 32'(oFRAME_CNT), 32'd5);
        check("stop_err", 32'(oERR), 32'd0);
        send_frame(24, 0, -1, 0, -1, 0, -1);
        check("idle_cnt", 32'(oFRAME_CNT), 32'd5);

        // Arm with iFVAL already high, reset mid-frame
        iFVAL = 1'b1;
        repeat (2) tick();
        iSTART = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 10; i++) begin
            iDVAL = 1'b1;
            iDATA = 12'(200 + i);
            if (i == 5) begin
                iRST = 1'b0;
                #1;
                check("arst_dval", 32'(oDVAL), 32'd0);
                check("arst_mode", 32'(oMODE), 32'd0);
                check("arst_cnt", 32'(oFRAME_CNT), 32'd0);
                check("arst_xy", {10'd0, oX_Cont, oY_Cont}, 32'd0);
                check("arst_err", 32'(oERR), 32'd0);
            end
            if (i == 7) iRST = 1'b1;
            tick();
        end
        iDVAL = 1'b0;
        iFVAL = 1'b0;
        repeat (3) tick();
        exp_mode = 2'd0;
        send_frame(24, 24, -1, 0, -1, 0, -1);
        check("post_rst_cnt", 32'(oFRAME_CNT), 32'd1);
        check("post_rst_err", 32'(oERR), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
